// File: rtl/bus_bram_slave.sv
// Serial bus slave that deserialises a transaction and issues exactly one BRAM access.
// Optional parity on the serial frames is enabled by defining BUS_PARITY_EN.
module bus_bram_slave #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_valid,
    input  logic                  bus_mode,
    input  logic                  bus_sin,
    output logic                  bus_ready,
    output logic                  bus_sout,
    output logic                  bus_sout_valid,
    output logic                  bus_done,
    output logic                  bus_err,
    output logic                  bram_rst,
    input  logic                  bram_rst_busy,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StAddr  = 4'd1;
    localparam logic [3:0] StWdata = 4'd2;
`ifdef BUS_PARITY_EN
    localparam logic [3:0] StPar   = 4'd3;
`endif
    localparam logic [3:0] StWrite = 4'd4;
    localparam logic [3:0] StRead  = 4'd5;
    localparam logic [3:0] StRwait = 4'd6;
    localparam logic [3:0] StRdata = 4'd7;
    localparam logic [3:0] StDone  = 4'd8;

    localparam int unsigned CntW = 8;
`ifdef BUS_PARITY_EN
    localparam int unsigned SoutW = DATA_WIDTH + 1;
`else
    localparam int unsigned SoutW = DATA_WIDTH;
`endif

    logic [3:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  valid_q;
    logic                  mode_q;
    logic                  start;
    logic                  wr_ok;
    logic                  bram_rst_q;
    logic [ADDR_WIDTH-1:0] addr_sr_q, addr_hold_q;
    logic [DATA_WIDTH-1:0] data_sr_q, din_hold_q;
    logic [SoutW-1:0]      sout_sr_q;
`ifdef BUS_PARITY_EN
    logic                  par_err_q;

    assign wr_ok   = ~par_err_q;
    assign bus_err = (state_q == StWrite) && par_err_q;
`else
    assign wr_ok   = 1'b1;
    assign bus_err = 1'b0;
`endif

    assign bram_rst       = bram_rst_q;
    assign bus_ready      = (state_q == StIdle) && !bram_rst_busy && !bram_rst_q;
    assign start          = bus_ready && bus_valid && !valid_q;
    assign bus_sout_valid = (state_q == StRdata);
    assign bus_sout       = bus_sout_valid & sout_sr_q[0];
    assign bus_done       = (state_q == StDone);
    assign bram_we        = (state_q == StWrite) && wr_ok;
    assign bram_en        = bram_we || (state_q == StRead);
    // Shift registers are exposed only during the access cycle; otherwise the last access holds.
    assign bram_addr = (state_q == StWrite || state_q == StRead) ? addr_sr_q : addr_hold_q;
    assign bram_din  = (state_q == StWrite) ? data_sr_q : din_hold_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) state_d = StAddr;
            end
            StAddr: begin
                if (!bus_valid) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(ADDR_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = mode_q ? StWdata : StRead;
                end
            end
            StWdata: begin
                if (!bus_valid) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                    cnt_d = '0;
`ifdef BUS_PARITY_EN
                    state_d = StPar;
`else
                    state_d = StWrite;
`endif
                end
            end
`ifdef BUS_PARITY_EN
            StPar:   state_d = bus_valid ? StWrite : StIdle;
`endif
            StWrite: state_d = StDone;
            StRead: begin
                cnt_d   = '0;
                state_d = StRwait;
            end
            StRwait: begin
                if (cnt_q == CntW'(READ_LATENCY - 1)) begin
                    cnt_d   = '0;
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if (cnt_q == CntW'(SoutW - 1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        bram_rst_q <= reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            mode_q      <= 1'b0;
            addr_sr_q   <= '0;
            addr_hold_q <= '0;
            data_sr_q   <= '0;
            din_hold_q  <= '0;
            sout_sr_q   <= '0;
`ifdef BUS_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= bus_valid;
            case (state_q)
                StIdle:  if (start) mode_q <= bus_mode;
                StAddr:  addr_sr_q <= {bus_sin, addr_sr_q[ADDR_WIDTH-1:1]};
                StWdata: data_sr_q <= {bus_sin, data_sr_q[DATA_WIDTH-1:1]};
`ifdef BUS_PARITY_EN
                StPar:   par_err_q <= bus_sin ^ (^{addr_sr_q, data_sr_q});
`endif
                StWrite: begin
                    addr_hold_q <= addr_sr_q;
                    din_hold_q  <= data_sr_q;
                end
                StRead:  addr_hold_q <= addr_sr_q;
                StRwait: begin
                    if (cnt_q == CntW'(READ_LATENCY - 1)) begin
`ifdef BUS_PARITY_EN
                        sout_sr_q <= {^{addr_sr_q, bram_dout}, bram_dout};
`else
                        sout_sr_q <= bram_dout;
`endif
                    end
                end
                StRdata: sout_sr_q <= sout_sr_q >> 1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bus_bram_slave.md
# bus_bram_slave

Serial system-bus slave controller sitting directly upstream of the 4096-byte block RAM (`bram_4096`). It deserialises bus transactions (mode, 12-bit address, 8-bit write data) from the master, drives the BRAM port for exactly one access per transaction, and serialises read data back onto the bus. It also sequences BRAM reset and holds off the bus while the BRAM reports reset-busy.

## Interface
- `ADDR_WIDTH`, 12: BRAM address width, serial address length.
- `DATA_WIDTH`, 8: BRAM data width, serial data length.
- `READ_LATENCY`, 1: cycles from `bram_en` (read) to valid `bram_dout`; legal values 1 or 2.

- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `bus_valid` in 1: master holds high for the whole transaction.
- `bus_mode` in 1: 1 = write, 0 = read; sampled in the start cycle only.
- `bus_sin` in 1: serial address then write data, LSB first.
- `bus_ready` out 1: slave can accept a start.
- `bus_sout` out 1: serial read data, LSB first.
- `bus_sout_valid` out 1: high while `bus_sout` carries a valid bit.
- `bus_done` out 1: one-cycle pulse at transaction end.
- `bus_err` out 1: one-cycle parity-error pulse (parity build only).
- `bram_rst` out 1: BRAM reset (`rsta`).
- `bram_rst_busy` in 1: BRAM `rsta_busy`.
- `bram_en`, `bram_we` out 1: BRAM `ena`, `wea`.
- `bram_addr` out ADDR_WIDTH; `bram_din` out DATA_WIDTH; `bram_dout` in DATA_WIDTH.

## Operation
- States: IDLE, ADDR, WDATA, (PAR), WRITE, READ, RWAIT, RDATA, DONE.
- Start: in IDLE, `bus_valid`=1 while previous-cycle `bus_valid`=0 and `bus_ready`=1; latch `bus_mode`, go ADDR. Level-high `bus_valid` without a rising edge never starts.
- `bus_ready` = state is IDLE and `bram_rst_busy`=0 and `bram_rst`=0.
- ADDR: shift ADDR_WIDTH bits into address register; then WDATA (write) or READ (read).
- WDATA: shift DATA_WIDTH bits; then WRITE (or PAR if parity build).
- WRITE: one cycle `bram_en`=`bram_we`=1 with latched address/data; then DONE.
- READ: one cycle `bram_en`=1, `bram_we`=0; RWAIT for READ_LATENCY cycles; capture `bram_dout` in last RWAIT cycle; RDATA shifts DATA_WIDTH bits out with `bus_sout_valid`=1; then DONE.
- DONE: `bus_done`=1 one cycle; return IDLE.
- Abort: `bus_valid`=0 in ADDR, WDATA or PAR -> IDLE next cycle, no BRAM access, no `bus_done`. In WRITE/READ/RWAIT/RDATA `bus_valid` is ignored; access completes.
- `bram_en`/`bram_we` are never high outside WRITE/READ; `bram_addr`/`bram_din` hold last latched values.

## Timing
- Reset values: state IDLE, `bus_sout`=0, `bus_sout_valid`=0, `bus_done`=0, `bus_err`=0, `bram_en`=`bram_we`=0, `bram_addr`=0, `bram_din`=0, `bram_rst`=0 except as below.
- `bram_rst` registered from `reset`: high the cycle after each `reset`-high cycle. Reset mid-transaction aborts immediately; no BRAM access issued after reset is sampled.
- Start cycle S: address bits S+1..S+12.
- Write: data bits S+13..S+20, WRITE at S+21, `bus_done` at S+22.
- Read: READ at S+13, data captured at S+13+L, `bus_sout` bits S+14+L..S+21+L, `bus_done` S+22+L (L = READ_LATENCY).
- Earliest next start: S+24 (write), one cycle low on `bus_valid` required.

## Configuration
- `BUS_PARITY_EN` defined: write frame carries one extra bit after data (cycle S+21), even parity over address+data; WRITE moves to S+22, done S+23. Mismatch -> no BRAM write, `bus_err` pulse at S+22, `bus_done` at S+23. Read appends even-parity bit of address+data on `bus_sout` at S+22+L, done S+23+L.
- Undefined: no parity bits, `bus_err` tied 0, timing as above.

## Test plan
- Write 0xAA to addr 2 -> at S+21 `bram_en`=`bram_we`=1, `bram_addr`=2, `bram_din`=0xAA; `bus_done` at S+22.
- Read addr 2 after above, L=1 -> `bus_sout` 0,1,0,1,0,1,0,1 in S+15..S+22 with `bus_sout_valid`; `bus_done` S+23.
- Drop `bus_valid` after 5 address bits -> `bram_en` never asserts, no `bus_done`, `bus_ready`=1 next cycle.
- Hold `bram_rst_busy`=1, raise `bus_valid` -> `bus_ready`=0, no start; after busy clears, fresh rising edge starts normally.
- Assert `reset` during RDATA -> next cycle all outputs at reset values, `bram_rst`=1 one cycle.
- `BUS_PARITY_EN`: write 0x01 to addr 0 with parity bit 0 -> `bus_err` pulse, no `bram_we`, `bus_done` S+23.
